// File: rtl/paddle_ctrl.sv
// paddle_ctrl: per-player paddle controller, updated once per 60 Hz frame.
//   Buttons pass through 2-flop synchronisers; movement accelerates after a
//   held run of frames and clamps to the playfield. A one-shot FSM produces
//   the hit strobe followed by a cooldown window.
// Optional feature macro: PADDLE_AI_TRACK_EN (ai_mode selects ball tracking).
// Ports:
//   sixtyhz_clk   frame clock
//   resetn        synchronous active-low reset
//   enable        1 = game in play, 0 = paddle frozen and hit FSM idle
//   up_btn        move up (toward smaller y), asynchronous
//   down_btn      move down, asynchronous
//   hit_btn       hit request, asynchronous
//   ai_mode       auto-tracking select (only with PADDLE_AI_TRACK_EN)
//   ball_y        current ball row (only with PADDLE_AI_TRACK_EN)
//   x_out         paddle column, constant PADDLE_X
//   y_out         paddle top row
//   force_applied high while a hit is active
//   hit_ready     high when a new hit will be accepted
module paddle_ctrl #(
  parameter int unsigned PADDLE_X        = 4,
  parameter int unsigned PADDLE_H        = 20,
  parameter int unsigned Y_MIN           = 32,
  parameter int unsigned Y_MAX           = 119,
  parameter int unsigned ACCEL_FRAMES    = 8,
  parameter int unsigned HIT_FRAMES      = 6,
  parameter int unsigned COOLDOWN_FRAMES = 30
) (
  input  logic       sixtyhz_clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       up_btn,
  input  logic       down_btn,
  input  logic       hit_btn,
  input  logic       ai_mode,
  input  logic [6:0] ball_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic       force_applied,
  output logic       hit_ready
);

  localparam int unsigned Y_TOP = Y_MAX + 1 - PADDLE_H;
  localparam int unsigned Y_RST = (Y_MIN + Y_TOP) / 2;
  localparam int unsigned T_MAX = (HIT_FRAMES > COOLDOWN_FRAMES) ? HIT_FRAMES : COOLDOWN_FRAMES;
  localparam int unsigned TW    = $clog2(T_MAX + 1);
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {IDLE, HIT, COOLDOWN} hit_state_t;

  logic [1:0]    up_sync, down_sync, hit_sync;
  logic          up_s, down_s, hit_s, hit_d, hit_rise;
  logic          move_up, move_dn;
  logic [CW-1:0] cnt, cnt_eff, cnt_nxt;
  logic          last_dn, last_dn_nxt;
  logic [7:0]    y8, step, y_cand;
  logic [6:0]    y_nxt;
  hit_state_t    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          force_nxt, ready_nxt;

  assign x_out    = 8'(PADDLE_X);
  assign up_s     = up_sync[1];
  assign down_s   = down_sync[1];
  assign hit_s    = hit_sync[1];
  assign hit_rise = hit_s & ~hit_d;
  assign move_up  = up_s & ~down_s;
  assign move_dn  = down_s & ~up_s;

`ifdef PADDLE_AI_TRACK_EN
  logic [7:0] ai_raw, ai_target;

  // Tracking target: ball centred on the paddle, clamped to the legal range.
  always_comb begin
    ai_raw = {1'b0, ball_y} - 8'(PADDLE_H / 2);
    if (ball_y < 7'(PADDLE_H / 2) || ai_raw < 8'(Y_MIN)) begin
      ai_target = 8'(Y_MIN);
    end else if (ai_raw > 8'(Y_TOP)) begin
      ai_target = 8'(Y_TOP);
    end else begin
      ai_target = ai_raw;
    end
  end
`else
  logic unused_ai;
  assign unused_ai = ^{ai_mode, ball_y};
`endif

  // Button synchronisers; hit_d runs even while disabled so stale edges die.
  always_ff @(posedge sixtyhz_clk) begin
    if (!resetn) begin
      up_sync   <= '0;
      down_sync <= '0;
      hit_sync  <= '0;
      hit_d     <= 1'b0;
    end else begin
      up_sync   <= {up_sync[0], up_btn};
      down_sync <= {down_sync[0], down_btn};
      hit_sync  <= {hit_sync[0], hit_btn};
      hit_d     <= hit_s;
    end
  end

  // Movement: hold-to-accelerate with clamping; a reversal restarts the count.
  always_comb begin
    y_nxt       = y_out;
    cnt_nxt     = '0;
    last_dn_nxt = last_dn;
    y8          = {1'b0, y_out};
    cnt_eff     = cnt;
    step        = 8'd1;
    y_cand      = y8;
    if (enable) begin
      if (move_up || move_dn) begin
        if (cnt != '0 && last_dn != move_dn) cnt_eff = '0;
        step        = (32'(cnt_eff) < ACCEL_FRAMES) ? 8'd1 : 8'd2;
        cnt_nxt     = (cnt_eff == 4'd15) ? 4'd15 : cnt_eff + 4'd1;
        last_dn_nxt = move_dn;
        if (move_up) begin
          y_cand = y8 - step;
          if (y_cand < 8'(Y_MIN)) y_cand = 8'(Y_MIN);
        end else begin
          y_cand = y8 + step;
          if (y_cand > 8'(Y_TOP)) y_cand = 8'(Y_TOP);
        end
        y_nxt = y_cand[6:0];
      end
`ifdef PADDLE_AI_TRACK_EN
      if (ai_mode) begin
        cnt_nxt     = '0;
        last_dn_nxt = last_dn;
        if (y8 < ai_target) begin
          y_nxt = 7'(y8 + 8'd1);
        end else if (y8 > ai_target) begin
          y_nxt = 7'(y8 - 8'd1);
        end else begin
          y_nxt = y_out;
        end
      end
`endif
    end
  end

  // Hit one-shot: IDLE -> HIT (HIT_FRAMES) -> COOLDOWN (COOLDOWN_FRAMES) -> IDLE.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    force_nxt = force_applied;
    ready_nxt = hit_ready;
    if (!enable) begin
      state_nxt = IDLE;
      timer_nxt = '0;
      force_nxt = 1'b0;
      ready_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          force_nxt = 1'b0;
          ready_nxt = 1'b1;
          if (hit_rise) begin
            state_nxt = HIT;
            timer_nxt = TW'(HIT_FRAMES - 1);
            force_nxt = 1'b1;
            ready_nxt = 1'b0;
          end
        end
        HIT: begin
          force_nxt = 1'b1;
          ready_nxt = 1'b0;
          if (timer == '0) begin
            state_nxt = COOLDOWN;
            timer_nxt = TW'(COOLDOWN_FRAMES - 1);
            force_nxt = 1'b0;
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
        COOLDOWN: begin
          force_nxt = 1'b0;
          ready_nxt = 1'b0;
          if (timer == '0) begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          timer_nxt = '0;
          force_nxt = 1'b0;
          ready_nxt = 1'b1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge sixtyhz_clk) begin
    if (!resetn) begin
      state         <= IDLE;
      timer         <= '0;
      force_applied <= 1'b0;
      hit_ready     <= 1'b1;
      y_out         <= 7'(Y_RST);
      cnt           <= '0;
      last_dn       <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      force_applied <= force_nxt;
      hit_ready     <= ready_nxt;
      y_out         <= y_nxt;
      cnt           <= cnt_nxt;
      last_dn       <= last_dn_nxt;
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed bench for paddle_ctrl. A vector table covers the
// basic movement/enable behaviour; hand-written sequences cover acceleration,
// clamping, reversal, hit timing, and reset/disable during a hit.
module tb_paddle_ctrl;

  logic       sixtyhz_clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       up_btn;
  logic       down_btn;
  logic       hit_btn;
  logic       ai_mode;
  logic [6:0] ball_y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic       force_applied;
  logic       hit_ready;

  int errors = 0;
  int checks = 0;

  paddle_ctrl dut (
    .sixtyhz_clk  (sixtyhz_clk),
    .resetn       (resetn),
    .enable       (enable),
    .up_btn       (up_btn),
    .down_btn     (down_btn),
    .hit_btn      (hit_btn),
    .ai_mode      (ai_mode),
    .ball_y       (ball_y),
    .x_out        (x_out),
    .y_out        (y_out),
    .force_applied(force_applied),
    .hit_ready    (hit_ready)
  );

  always #5 sixtyhz_clk = ~sixtyhz_clk;

  typedef struct {
    logic up;
    logic dn;
    logic hit;
    logic en;
    int   y;
    logic f;
    logic r;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs[NVEC];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sixtyhz_clk);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    enable   = 1'b1;
    up_btn   = 1'b0;
    down_btn = 1'b0;
    hit_btn  = 1'b0;
    ai_mode  = 1'b0;
    ball_y   = 7'd0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic set_vec(input int i, input logic up, input logic dn,
                         input logic hit, input logic en, input int y);
    vecs[i].up  = up;
    vecs[i].dn  = dn;
    vecs[i].hit = hit;
    vecs[i].en  = en;
    vecs[i].y   = y;
    vecs[i].f   = 1'b0;
    vecs[i].r   = 1'b1;
  endtask

  initial begin
    int exp_y;
    int exp_f;
    int exp_r;

    // Table: both held, release down, disable with a hit pulse, stop, go down.
    for (int i = 0; i < 10; i++) set_vec(i, 1'b1, 1'b1, 1'b0, 1'b1, 66);
    set_vec(10, 1'b1, 1'b0, 1'b0, 1'b1, 66);
    set_vec(11, 1'b1, 1'b0, 1'b0, 1'b1, 66);
    for (int i = 12; i < 18; i++) set_vec(i, 1'b1, 1'b0, 1'b0, 1'b1, 77 - i);
    set_vec(18, 1'b1, 1'b0, 1'b1, 1'b0, 60);
    set_vec(19, 1'b1, 1'b0, 1'b0, 1'b0, 60);
    set_vec(20, 1'b1, 1'b0, 1'b0, 1'b0, 60);
    set_vec(21, 1'b1, 1'b0, 1'b0, 1'b1, 59);
    set_vec(22, 1'b1, 1'b0, 1'b0, 1'b1, 58);
    set_vec(23, 1'b0, 1'b0, 1'b0, 1'b1, 57);
    set_vec(24, 1'b0, 1'b0, 1'b0, 1'b1, 56);
    set_vec(25, 1'b0, 1'b0, 1'b0, 1'b1, 56);
    set_vec(26, 1'b0, 1'b0, 1'b0, 1'b1, 56);
    set_vec(27, 1'b0, 1'b1, 1'b0, 1'b1, 56);
    set_vec(28, 1'b0, 1'b1, 1'b0, 1'b1, 56);
    set_vec(29, 1'b0, 1'b1, 1'b0, 1'b1, 57);
    set_vec(30, 1'b0, 1'b1, 1'b0, 1'b1, 58);

    // Reset values.
    do_reset();
    check("reset_y", int'(y_out), 66);
    check("reset_x", int'(x_out), 4);
    check("reset_force", int'(force_applied), 0);
    check("reset_ready", int'(hit_ready), 1);

    for (int i = 0; i < NVEC; i++) begin
      up_btn   = vecs[i].up;
      down_btn = vecs[i].dn;
      hit_btn  = vecs[i].hit;
      enable   = vecs[i].en;
      tick();
      check($sformatf("vec%0d_y", i), int'(y_out), vecs[i].y);
      check($sformatf("vec%0d_force", i), int'(force_applied), int'(vecs[i].f));
      check($sformatf("vec%0d_ready", i), int'(hit_ready), int'(vecs[i].r));
    end
    check("vec_x", int'(x_out), 4);

    // Up held: 8 single steps, then 2 px/frame, clamp at 32 from edge 22.
    do_reset();
    up_btn = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      tick();
      if (e < 2) exp_y = 66;
      else if (e <= 9) exp_y = 67 - e;
      else exp_y = 58 - 2 * (e - 9);
      if (exp_y < 32) exp_y = 32;
      check($sformatf("accel_up_e%0d", e), int'(y_out), exp_y);
    end

    // Reversal at saturated count restarts at 1 px/frame; clamp at 100.
    up_btn   = 1'b0;
    down_btn = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      tick();
      if (k < 2) exp_y = 32;
      else if (k <= 9) exp_y = 31 + k;
      else exp_y = 40 + 2 * (k - 9);
      if (exp_y > 100) exp_y = 100;
      check($sformatf("reverse_k%0d", k), int'(y_out), exp_y);
    end
    down_btn = 1'b0;

    // Hit timing: pulse at 0, ignored pulse at 20, held from 40 to 89.
    do_reset();
    for (int e = 0; e <= 95; e++) begin
      hit_btn = (e == 0) || (e == 20) || (e >= 40 && e <= 89);
      tick();
      exp_f = ((e >= 2 && e <= 7) || (e >= 42 && e <= 47)) ? 1 : 0;
      exp_r = ((e >= 2 && e <= 37) || (e >= 42 && e <= 77)) ? 0 : 1;
      check($sformatf("hit_force_e%0d", e), int'(force_applied), exp_f);
      check($sformatf("hit_ready_e%0d", e), int'(hit_ready), exp_r);
    end
    hit_btn = 1'b0;

    // Reset on the third HIT frame while moving down.
    do_reset();
    down_btn = 1'b1;
    hit_btn  = 1'b1;
    tick();
    hit_btn = 1'b0;
    tick();
    tick();
    check("midhit_force_e2", int'(force_applied), 1);
    check("midhit_y_e2", int'(y_out), 67);
    tick();
    check("midhit_y_e3", int'(y_out), 68);
    check("midhit_ready_e3", int'(hit_ready), 0);
    resetn = 1'b0;
    tick();
    check("midhit_rst_force", int'(force_applied), 0);
    check("midhit_rst_ready", int'(hit_ready), 1);
    check("midhit_rst_y", int'(y_out), 66);
    resetn   = 1'b1;
    down_btn = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      check($sformatf("postrst_force_e%0d", e), int'(force_applied), 0);
      check($sformatf("postrst_y_e%0d", e), int'(y_out), 66);
    end

    // Disable during HIT forces IDLE immediately.
    do_reset();
    hit_btn = 1'b1;
    tick();
    hit_btn = 1'b0;
    tick();
    tick();
    check("dis_force_before", int'(force_applied), 1);
    enable = 1'b0;
    tick();
    check("dis_force", int'(force_applied), 0);
    check("dis_ready", int'(hit_ready), 1);
    enable = 1'b1;
    tick();
    check("reen_force", int'(force_applied), 0);
    check("reen_ready", int'(hit_ready), 1);

`ifdef PADDLE_AI_TRACK_EN
    // Tracking toward a clamped target; buttons ignored.
    do_reset();
    ai_mode = 1'b1;
    ball_y  = 7'd110;
    up_btn  = 1'b1;
    for (int e = 0; e < 40; e++) begin
      tick();
      exp_y = 67 + e;
      if (exp_y > 100) exp_y = 100;
      check($sformatf("ai_down_e%0d", e), int'(y_out), exp_y);
    end
    ball_y = 7'd20;
    for (int e = 0; e < 10; e++) begin
      tick();
      check($sformatf("ai_up_e%0d", e), int'(y_out), 99 - e);
    end
`else
    // ai_mode has no effect in this build.
    do_reset();
    ai_mode = 1'b1;
    ball_y  = 7'd110;
    for (int e = 0; e < 5; e++) begin
      tick();
      check($sformatf("ai_ignored_e%0d", e), int'(y_out), 66);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
